// File: rtl/adat_smux_deframer_if.sv
// Bundles the deframer's bit-stream inputs, RAM write port and frame status.
// The slave modport is the deframer; the master modport is whoever feeds the
// stream and consumes the RAM writes and status.
interface adat_smux_deframer_if #(
  parameter int CIRC_BUF_BITS = 3,
  parameter int ERR_CNT_BITS  = 16
);
  logic                       tick_ni;
  logic                       bit_i;
  logic                       bit_valid_i;
  logic                       sync_i;
  logic [1:0]                 smux_i;
  logic                       ram_write_en_o;
  logic [CIRC_BUF_BITS+7:0]   ram_write_addr_o;
  logic                       ram_write_data_o;
  logic [CIRC_BUF_BITS-1:0]   last_good_frame_idx_o;
  logic [1:0]                 frame_mode_o;
  logic                       frame_commit_o;
  logic [3:0]                 user_bits_o;
  logic [ERR_CNT_BITS-1:0]    err_count_o;
  logic                       has_sync_o;

  modport master (
    output tick_ni, bit_i, bit_valid_i, sync_i, smux_i,
    input  ram_write_en_o, ram_write_addr_o, ram_write_data_o,
           last_good_frame_idx_o, frame_mode_o, frame_commit_o,
           user_bits_o, err_count_o, has_sync_o
  );

  modport slave (
    input  tick_ni, bit_i, bit_valid_i, sync_i, smux_i,
    output ram_write_en_o, ram_write_addr_o, ram_write_data_o,
           last_good_frame_idx_o, frame_mode_o, frame_commit_o,
           user_bits_o, err_count_o, has_sync_o
  );
endinterface

// File: rtl/adat_smux_deframer.sv
// ADAT frame deframer with S/MUX2/S/MUX4 slot remapping. Takes the bit stream
// from the NRZI phase-lock decoder, writes every payload bit into a circular
// frame buffer, commits whole frames, and tracks lock with hysteresis.
module adat_smux_deframer #(
  parameter int CIRC_BUF_BITS = 3,
  parameter int LOCK_FRAMES   = 2,
  parameter int UNLOCK_ERRORS = 4,
  parameter int ERR_CNT_BITS  = 16,
  parameter int SYNC_QUAL     = 3
) (
  input logic                 clk_x4_i,
  input logic                 reset_i,
  adat_smux_deframer_if.slave bus
);

  localparam int SyncW   = (SYNC_QUAL > 1) ? $clog2(SYNC_QUAL) : 1;
  localparam int LockW   = $clog2(LOCK_FRAMES + 1);
  localparam int UnlockW = $clog2(UNLOCK_ERRORS + 1);
  localparam logic [SyncW-1:0]   SyncLast  = SyncW'(SYNC_QUAL - 1);
  localparam logic [LockW-1:0]   LockMax   = LockW'(LOCK_FRAMES);
  localparam logic [UnlockW-1:0] UnlockMax = UnlockW'(UNLOCK_ERRORS);

  typedef enum logic [2:0] {
    StIdle,
    StWaitNrzi,
    StWaitSync,
    StUser,
    StSamples,
    StCommit,
    StError
  } state_t;

  state_t                   state;
  logic [SyncW-1:0]         sync_cnt;
  logic [CIRC_BUF_BITS-1:0] frame_idx;
  logic [1:0]               cur_mode;
  logic [3:0]               user_shift;
  logic [2:0]               user_pos;
  logic [2:0]               slot;
  logic [2:0]               pos;
  logic [4:0]               bit_idx;
  logic [LockW-1:0]         good_cnt;
  logic [LockW-1:0]         good_next;
  logic [UnlockW-1:0]       bad_cnt;
  logic [UnlockW-1:0]       bad_next;
  logic [1:0]               smux_norm;

  logic                     write_en;
  logic [CIRC_BUF_BITS+7:0] write_addr;
  logic                     write_data;
  logic [CIRC_BUF_BITS-1:0] last_idx;
  logic [1:0]               mode_out;
  logic                     commit;
  logic [3:0]               user_out;
  logic [ERR_CNT_BITS-1:0]  err_cnt;
  logic                     has_sync;

  assign bus.ram_write_en_o        = write_en;
  assign bus.ram_write_addr_o      = write_addr;
  assign bus.ram_write_data_o      = write_data;
  assign bus.last_good_frame_idx_o = last_idx;
  assign bus.frame_mode_o          = mode_out;
  assign bus.frame_commit_o        = commit;
  assign bus.user_bits_o           = user_out;
  assign bus.err_count_o           = err_cnt;
  assign bus.has_sync_o            = has_sync;

  // Slot remap: S/MUX spreads one channel's sub-samples over adjacent slots,
  // so the RAM address is rearranged to {sub-sample, channel}.
  function automatic logic [2:0] remap(input logic [2:0] s, input logic [1:0] m);
    case (m)
      2'b01:   remap = {s[0], s[2:1]};
      2'b10:   remap = {s[1:0], s[2]};
      default: remap = s;
    endcase
  endfunction

  // Saturating next values of the lock counters and the normalised mode.
  always_comb begin
    good_next = (good_cnt == LockMax) ? good_cnt : good_cnt + 1'b1;
    bad_next  = (bad_cnt == UnlockMax) ? bad_cnt : bad_cnt + 1'b1;
    smux_norm = (bus.smux_i == 2'b11) ? 2'b00 : bus.smux_i;
  end

  // Frame FSM, RAM write port, commit/status registers and lock tracking.
  always_ff @(posedge clk_x4_i) begin
    if (reset_i) begin
      state      <= StIdle;
      sync_cnt   <= '0;
      frame_idx  <= '0;
      cur_mode   <= 2'b00;
      user_shift <= 4'b0;
      user_pos   <= 3'd0;
      slot       <= 3'd0;
      pos        <= 3'd0;
      bit_idx    <= 5'd0;
      good_cnt   <= '0;
      bad_cnt    <= '0;
      write_en   <= 1'b0;
      write_addr <= '0;
      write_data <= 1'b0;
      last_idx   <= '0;
      mode_out   <= 2'b00;
      commit     <= 1'b0;
      user_out   <= 4'b0;
      err_cnt    <= '0;
      has_sync   <= 1'b0;
    end else begin
      write_en <= 1'b0;
      commit   <= 1'b0;
      if (!bus.tick_ni) begin
        if (state != StWaitSync) sync_cnt <= '0;
        case (state)
          StIdle: state <= StWaitNrzi;
          StWaitNrzi: begin
            if (bus.bit_valid_i) state <= StWaitSync;
          end
          StWaitSync: begin
            if (!bus.bit_valid_i) begin
              state    <= StWaitNrzi;
              sync_cnt <= '0;
            end else if (bus.sync_i) begin
              if (sync_cnt == SyncLast) begin
                sync_cnt <= '0;
                cur_mode <= smux_norm;
                user_pos <= 3'd0;
                state    <= StUser;
              end else begin
                sync_cnt <= sync_cnt + 1'b1;
              end
            end else begin
              sync_cnt <= '0;
            end
          end
          StUser: begin
            if (!bus.bit_valid_i || (user_pos == 3'd0 && !bus.bit_i)) begin
              state <= StError;
            end else begin
              if (user_pos != 3'd0) user_shift <= {bus.bit_i, user_shift[3:1]};
              if (user_pos == 3'd4) begin
                state   <= StSamples;
                slot    <= 3'd0;
                pos     <= 3'd0;
                bit_idx <= 5'd0;
              end else begin
                user_pos <= user_pos + 3'd1;
              end
            end
          end
          StSamples: begin
            if (!bus.bit_valid_i || (pos == 3'd0 && !bus.bit_i)) begin
              state <= StError;
            end else if (pos == 3'd0) begin
              pos <= 3'd1;
            end else begin
              write_en   <= 1'b1;
              write_data <= bus.bit_i;
              write_addr <= {frame_idx, remap(slot, cur_mode), bit_idx};
              pos        <= (pos == 3'd4) ? 3'd0 : pos + 3'd1;
              if (bit_idx == 5'd23) begin
                bit_idx <= 5'd0;
                if (slot == 3'd7) state <= StCommit;
                else slot <= slot + 3'd1;
              end else begin
                bit_idx <= bit_idx + 5'd1;
              end
            end
          end
          StCommit: begin
            last_idx  <= frame_idx;
            user_out  <= user_shift;
            mode_out  <= cur_mode;
            commit    <= 1'b1;
            frame_idx <= frame_idx + 1'b1;
            good_cnt  <= good_next;
            bad_cnt   <= '0;
            if (good_next == LockMax) has_sync <= 1'b1;
            state     <= StWaitSync;
          end
          StError: begin
            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            bad_cnt  <= bad_next;
            good_cnt <= '0;
            if (bad_next == UnlockMax) has_sync <= 1'b0;
            state    <= bus.bit_valid_i ? StWaitSync : StWaitNrzi;
          end
          default: state <= StIdle;
        endcase
        if (!bus.bit_valid_i) has_sync <= 1'b0;
      end
    end
  end

endmodule
